// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the memory-mapped I/O bridge: address map, STATUS layout
// and the write-capture FSM states.
package mem_io_bridge_pkg;

  localparam int BITS_DATA  = 32;
  localparam int BITS_ADDR  = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BITS_ADDR-1:0] IO_BASE   = 16'hFFF0;
  localparam logic [BITS_ADDR-1:0] IO_TXDATA = 16'hFFF0;
  localparam logic [BITS_ADDR-1:0] IO_STATUS = 16'hFFF1;
  localparam logic [BITS_ADDR-1:0] IO_CYCLES = 16'hFFF2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic {
    WRS_IDLE = 1'b0,
    WRS_PEND = 1'b1
  } wr_state_t;

  function automatic logic is_io(input logic [BITS_ADDR-1:0] addr);
    return addr >= IO_BASE;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU memory port, RAM port and TX drain port bundled as one bus.
// The bridge is the slave; the CPU/RAM/consumer side is the master.
interface mem_io_bridge_if;
  import mem_io_bridge_pkg::*;

  logic [BITS_ADDR-1:0] MAR;
  logic [BITS_DATA-1:0] MBR_W;
  logic                 write;
  logic [BITS_DATA-1:0] MBR_R;
  logic [BITS_ADDR-1:0] ram_addr;
  logic [BITS_DATA-1:0] ram_data_w;
  logic                 ram_write;
  logic [BITS_DATA-1:0] ram_data_r;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport slave (
    input  MAR, MBR_W, write, ram_data_r, tx_ready,
    output MBR_R, ram_addr, ram_data_w, ram_write, tx_data, tx_valid
  );

  modport master (
    output MAR, MBR_W, write, ram_data_r, tx_ready,
    input  MBR_R, ram_addr, ram_data_w, ram_write, tx_data, tx_valid
  );

endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// First-word-fall-through FIFO. A push into a full FIFO is still accepted when
// a pop happens in the same cycle; dout reads as zero while empty.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  // Storage needs no reset: empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the CPU memory port and RAM, decoding the top 16 addresses
// into TX FIFO, STATUS and a free-running cycle counter.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mem_io_bridge_if.slave bus
);

  wr_state_t            state, state_nxt;
  logic                 write_q;
  logic [BITS_ADDR-1:0] io_addr, io_addr_nxt;
  logic                 commit;

  logic                 io_sel;
  logic                 pop;
  logic                 push_req;
  logic                 overflow;
  logic                 overflow_set;
  logic                 overflow_clr;
  logic [31:0]          cycles;
  logic [BITS_DATA-1:0] status;
  logic [BITS_DATA-1:0] io_rdata;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [7:0]           fifo_dout;

  assign io_sel         = is_io(bus.MAR);
  assign bus.ram_addr   = bus.MAR;
  assign bus.ram_data_w = bus.MBR_W;
  assign bus.ram_write  = bus.write && !io_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WRS_IDLE;
      write_q <= 1'b0;
      io_addr <= '0;
    end else begin
      state   <= state_nxt;
      write_q <= bus.write;
      io_addr <= io_addr_nxt;
    end
  end

  // Write data arrives one cycle after the write rise, so the commit is deferred.
  always_comb begin
    state_nxt   = state;
    io_addr_nxt = io_addr;
    commit      = 1'b0;
    case (state)
      WRS_IDLE: begin
        if (bus.write && !write_q && io_sel) begin
          io_addr_nxt = bus.MAR;
          state_nxt   = WRS_PEND;
        end
      end
      WRS_PEND: begin
        commit    = 1'b1;
        state_nxt = WRS_IDLE;
      end
    endcase
  end

  assign pop          = !fifo_empty && bus.tx_ready;
  assign push_req     = commit && (io_addr == IO_TXDATA);
  assign overflow_set = push_req && fifo_full && !pop;
  assign overflow_clr = (bus.MAR == IO_STATUS) && !bus.write;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (bus.MBR_W[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.tx_data  = fifo_dout;
  assign bus.tx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      cycles   <= '0;
    end else begin
      if (overflow_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (commit && (io_addr == IO_CYCLES)) cycles <= '0;
      else                                  cycles <= cycles + 32'd1;
    end
  end

  always_comb begin
    status                             = '0;
    status[ST_FULL]                    = fifo_full;
    status[ST_EMPTY]                   = fifo_empty;
    status[ST_OVERFLOW]                = overflow;
    status[ST_COUNT_LSB +: CNT_W]      = fifo_count;
  end

  always_comb begin
    io_rdata = '0;
    case (bus.MAR)
      IO_STATUS: io_rdata = status;
      IO_CYCLES: io_rdata = cycles;
      default:   io_rdata = '0;
    endcase
  end

  assign bus.MBR_R = io_sel ? io_rdata : bus.ram_data_r;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomised bench for mem_io_bridge with a queue-based reference model,
// a per-cycle compare process and a few hand-computed literal expectations.
module tb_mem_io_bridge;
  import mem_io_bridge_pkg::*;

  localparam int K_MBR   = 0;
  localparam int K_VALID = 1;
  localparam int K_TDATA = 2;
  localparam int K_RAMWR = 3;
  localparam int K_RAMDW = 4;

  logic clk = 1'b0;
  logic reset;
  mem_io_bridge_if bus();

  mem_io_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference model state: the TX FIFO is just a queue of bytes.
  byte unsigned mq[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cycles = '0;
  logic        m_wq = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_pend_next;
  logic [15:0] m_paddr = '0;
  logic        m_full, m_pop, m_set;
  int          wrap_req = 0;
  int          wrap_ack = 0;

  int          lit_kind [64];
  logic [31:0] lit_exp  [64];
  int          lit_wr = 0;
  int          lit_rd = 0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_cycles = '0;
      m_wq     = 1'b0;
      m_pend   = 1'b0;
      m_paddr  = '0;
      wrap_ack = wrap_req;
    end else begin
      if (wrap_req != wrap_ack) begin
        m_cycles = 32'hFFFF_FFFF;
        wrap_ack = wrap_req;
      end
      m_full = (mq.size() == FIFO_DEPTH);
      m_pop  = (mq.size() != 0) && bus.tx_ready;
      m_set  = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_pend && m_paddr == IO_TXDATA) begin
        if (!m_full || m_pop) mq.push_back(bus.MBR_W[7:0]);
        else                  m_set = 1'b1;
      end
      if (m_set) m_ovf = 1'b1;
      else if (bus.MAR == IO_STATUS && !bus.write) m_ovf = 1'b0;
      if (m_pend && m_paddr == IO_CYCLES) m_cycles = '0;
      else                                m_cycles = m_cycles + 32'd1;
      m_pend_next = !m_pend && bus.write && !m_wq && (bus.MAR >= IO_BASE);
      if (m_pend_next) m_paddr = bus.MAR;
      m_pend = m_pend_next;
      m_wq   = bus.write;
    end
  end

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s      = '0;
    s[0]   = (mq.size() == FIFO_DEPTH);
    s[1]   = (mq.size() == 0);
    s[2]   = m_ovf;
    s[7:4] = 4'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] modelRead();
    logic [31:0] cyc;
    cyc = (wrap_req != wrap_ack) ? 32'hFFFF_FFFF : m_cycles;
    if (bus.MAR < IO_BASE)   return bus.ram_data_r;
    if (bus.MAR == IO_STATUS) return modelStatus();
    if (bus.MAR == IO_CYCLES) return cyc;
    return 32'h0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
    cmp("ram_addr",   32'(bus.ram_addr),   32'(bus.MAR));
    cmp("ram_data_w", bus.ram_data_w,      bus.MBR_W);
    cmp("ram_write",  32'(bus.ram_write),  32'(bus.write && bus.MAR < IO_BASE));
    cmp("MBR_R",      bus.MBR_R,           modelRead());
    cmp("tx_valid",   32'(bus.tx_valid),   32'(mq.size() != 0));
    cmp("tx_data",    32'(bus.tx_data),    32'(exp_data));
  endtask

  task automatic checkLiteral(input int kind, input logic [31:0] exp);
    case (kind)
      K_MBR:   cmp("lit_MBR_R",      bus.MBR_R,             exp);
      K_VALID: cmp("lit_tx_valid",   32'(bus.tx_valid),     exp);
      K_TDATA: cmp("lit_tx_data",    32'(bus.tx_data),      exp);
      K_RAMWR: cmp("lit_ram_write",  32'(bus.ram_write),    exp);
      default: cmp("lit_ram_data_w", bus.ram_data_w,        exp);
    endcase
  endtask

  // Single compare process: model check every cycle plus any queued literals.
  always @(negedge clk) begin
    if (started) begin
      checkOutput();
      while (lit_rd != lit_wr) begin
        checkLiteral(lit_kind[lit_rd % 64], lit_exp[lit_rd % 64]);
        lit_rd++;
      end
    end
  end

  task automatic expectLit(input int kind, input logic [31:0] exp);
    lit_kind[lit_wr % 64] = kind;
    lit_exp[lit_wr % 64]  = exp;
    lit_wr++;
  endtask

  task automatic applyStimulus(input logic rst, input logic [15:0] mar,
                               input logic [31:0] wdata, input logic wr, input logic rdy);
    @(posedge clk);
    #2;
    reset          = rst;
    bus.MAR        = mar;
    bus.MBR_W      = wdata;
    bus.write      = wr;
    bus.tx_ready   = rdy;
    bus.ram_data_r = $urandom;
  endtask

  // CPU-style store: write rises with junk data, valid data follows a cycle later.
  task automatic cpuStore(input logic [15:0] addr, input logic [31:0] data, input int hold,
                          input logic rdy_a, input logic rdy_b, input logic rdy_c);
    applyStimulus(1'b0, addr, $urandom, 1'b1, rdy_a);
    applyStimulus(1'b0, addr, data, 1'b1, rdy_b);
    for (int i = 0; i < hold; i++) applyStimulus(1'b0, addr, data, 1'b1, 1'b0);
    applyStimulus(1'b0, addr, data, 1'b0, rdy_c);
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 7))
      0, 1, 2: return IO_TXDATA;
      3:       return IO_STATUS;
      4:       return IO_CYCLES;
      5:       return IO_BASE + 16'($urandom_range(3, 15));
      6:       return 16'hFFEF;
      default: return 16'($urandom_range(0, 32'hFFEF));
    endcase
  endfunction

  initial begin
    reset          = 1'b1;
    bus.MAR        = '0;
    bus.MBR_W      = '0;
    bus.write      = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.ram_data_r = '0;

    applyStimulus(1'b1, 16'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, IO_CYCLES, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0);
    expectLit(K_VALID, 32'h0);
    expectLit(K_TDATA, 32'h0);
    applyStimulus(1'b0, IO_CYCLES, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h1);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0002);

    applyStimulus(1'b0, 16'h0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    expectLit(K_RAMWR, 32'h1);
    expectLit(K_RAMDW, 32'hDEAD_BEEF);
    applyStimulus(1'b0, IO_TXDATA, 32'h0, 1'b1, 1'b0);
    expectLit(K_RAMWR, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);

    cpuStore(IO_TXDATA, 32'h0000_0141, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0010);
    expectLit(K_TDATA, 32'h41);
    expectLit(K_VALID, 32'h1);

    applyStimulus(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cpuStore(IO_TXDATA, 32'h10 + 32'(i), 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0085);
    expectLit(K_TDATA, 32'h10);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0081);

    cpuStore(IO_TXDATA, 32'h0000_00A5, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0081);
    expectLit(K_TDATA, 32'h11);

    cpuStore(IO_CYCLES, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0);
    applyStimulus(1'b0, IO_CYCLES, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h1);
    applyStimulus(1'b0, IO_CYCLES, 32'h0, 1'b0, 1'b0);
    force dut.cycles = 32'hFFFF_FFFF;
    #1;
    release dut.cycles;
    wrap_req++;
    expectLit(K_MBR, 32'hFFFF_FFFF);
    applyStimulus(1'b0, IO_CYCLES, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0);

    applyStimulus(1'b0, IO_TXDATA, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, IO_TXDATA, 32'h77, 1'b1, 1'b0);
    applyStimulus(1'b0, IO_TXDATA, 32'h77, 1'b0, 1'b0);
    expectLit(K_VALID, 32'h0);
    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    expectLit(K_MBR, 32'h0000_0002);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3:
          cpuStore(randAddr(), $urandom, $urandom_range(0, 2),
                   1'($urandom), 1'($urandom), 1'($urandom));
        4, 5, 6, 7:
          applyStimulus(1'b0, randAddr(), $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        8:
          applyStimulus(1'b0, IO_STATUS, $urandom, 1'b0, 1'($urandom));
        default:
          applyStimulus($urandom_range(0, 30) == 0, randAddr(), $urandom, 1'b0, 1'($urandom));
      endcase
    end

    applyStimulus(1'b0, IO_STATUS, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
